// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and constants for the BCD stopwatch core.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } sw_state_e;

    localparam logic [3:0] c_dig_max_dec  = 4'd9;
    localparam logic [3:0] c_dig_max_sex  = 4'd5;
    localparam int         c_sec_tens_idx = 3;

    // Seconds-tens wraps at 5; every other digit is a plain decade.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == c_sec_tens_idx) ? c_dig_max_sex : c_dig_max_dec;
    endfunction

    function automatic logic [6:0] seg7_pattern(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_stopwatch_core_seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational BCD to active-high 7-segment decoder (bit0=a).
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg7_pattern(bcd);

endmodule
`default_nettype wire

// File: rtl/bcd_stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch_core
//  Description : Prescaled BCD stopwatch with run/stop/clear FSM and
//                registered 7-segment outputs. Optional lap hold when the
//                LAP_HOLD_EN macro is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_HZ        = 100,
    parameter int MIN_DIGITS     = 2,
    parameter int ACTIVE_LOW_SEG = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_stop,
    input  logic                        clear,
    input  logic                        lap,
    output logic                        running,
    output logic                        overflow,
    output logic                        lap_hold,
    output logic [7*(4+MIN_DIGITS)-1:0] hex
);

    localparam int             NDIG         = 4 + MIN_DIGITS;
    localparam int             DIV          = CLK_HZ / TICK_HZ;
    localparam int             PW           = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  c_presc_last = PW'(DIV - 1);
    localparam logic [6:0]     c_seg_inv    = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic [6:0]     c_seg_zero   = seg7_pattern(4'd0) ^ c_seg_inv;

    sw_state_e              state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [NDIG-1:0][3:0]   digit_q, digit_d;
    logic [NDIG-1:0][3:0]   disp_digit;
    logic [NDIG-1:0][6:0]   seg_raw;
    logic [NDIG*7-1:0]      hex_q, hex_d;
    logic                   overflow_q, overflow_d;
    logic                   clr_accept;
    logic                   tick;
    logic                   wrap;

    // start_stop is checked first so it wins over a simultaneous clear.
    always_comb begin
        state_d    = state_q;
        clr_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_stop)  state_d = ST_RUN;
                else if (clear)  clr_accept = 1'b1;
            end
            ST_RUN: begin
                if (start_stop)  state_d = ST_STOP;
            end
            ST_STOP: begin
                if (start_stop) begin
                    state_d = ST_RUN;
                end else if (clear) begin
                    state_d    = ST_IDLE;
                    clr_accept = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tick = (state_q == ST_RUN) && (presc_q == c_presc_last);

    always_comb begin
        presc_d = presc_q;
        if (clr_accept)
            presc_d = '0;
        else if (state_q == ST_RUN)
            presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        logic carry;
        carry   = tick;
        digit_d = digit_q;
        for (int k = 0; k < NDIG; k++) begin
            if (carry)
                digit_d[k] = (digit_q[k] == digit_max(k)) ? 4'd0 : digit_q[k] + 4'd1;
            carry = carry && (digit_q[k] == digit_max(k));
        end
        wrap = carry;
        if (clr_accept)
            digit_d = '0;
    end

    assign overflow_d = clr_accept ? 1'b0 : (overflow_q | wrap);

`ifdef LAP_HOLD_EN
    logic [NDIG-1:0][3:0] hold_q, hold_d;
    logic                 lap_hold_q, lap_hold_d;

    // The snapshot is only taken on the arming press; the release press leaves it alone.
    always_comb begin
        hold_d     = hold_q;
        lap_hold_d = lap_hold_q;
        if (clr_accept) begin
            lap_hold_d = 1'b0;
        end else if ((state_q == ST_RUN) && lap) begin
            lap_hold_d = ~lap_hold_q;
            if (!lap_hold_q)
                hold_d = digit_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            lap_hold_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            lap_hold_q <= lap_hold_d;
        end
    end

    assign disp_digit = lap_hold_q ? hold_q : digit_q;
    assign lap_hold   = lap_hold_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign disp_digit = digit_q;
    assign lap_hold   = 1'b0;
`endif

    for (genvar k = 0; k < NDIG; k++) begin : g_seg
        seg7_decode u_seg7_decode (
            .bcd (disp_digit[k]),
            .seg (seg_raw[k])
        );
    end

    assign hex_d = seg_raw ^ {NDIG{c_seg_inv}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            digit_q    <= '0;
            overflow_q <= 1'b0;
            hex_q      <= {NDIG{c_seg_zero}};
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            digit_q    <= digit_d;
            overflow_q <= overflow_d;
            hex_q      <= hex_d;
        end
    end

    assign running  = (state_q == ST_RUN);
    assign overflow = overflow_q;
    assign hex      = hex_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_stopwatch_core
//  Description : Directed self-checking bench for bcd_stopwatch_core
//                (tick every 10 clk, two minute digits, active-low segments).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_stopwatch_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic        running;
    logic        overflow;
    logic        lap_hold;
    logic [41:0] hex;
    logic [23:0] force_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_stopwatch_core #(
        .CLK_HZ         (1000),
        .TICK_HZ        (100),
        .MIN_DIGITS     (2),
        .ACTIVE_LOW_SEG (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .running    (running),
        .overflow   (overflow),
        .lap_hold   (lap_hold),
        .hex        (hex)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_low(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;  4'd3: s = 7'h30;
            4'd4: s = 7'h19;  4'd5: s = 7'h12;  4'd6: s = 7'h02;  4'd7: s = 7'h78;
            4'd8: s = 7'h00;  4'd9: s = 7'h10;  default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Digits given as MM:SS.CC nibbles, e.g. 24'h015923 = 01:59.23.
    function automatic logic [41:0] exp_hex(input logic [23:0] d);
        logic [41:0] r;
        for (int k = 0; k < 6; k++)
            r[7*k +: 7] = seg_low(d[4*k +: 4]);
        return r;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clr();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
    endtask

    // From a stopped state: clear, preload the time, start with prescaler at 0.
    task automatic start_from(input logic [23:0] d);
        pulse_clr();
        force_val = d;
        force dut.digit_q = force_val;
        @(negedge clk);
        release dut.digit_q;
        pulse_ss();
    endtask

    initial begin
        rst_n      = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        force_val  = '0;
        wait_n(3);
        rst_n = 1'b1;
        check("rst_running",  running,  1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_lap_hold", lap_hold, 1'b0);
        check("rst_hex",      hex,      exp_hex(24'h000000));

        pulse_ss();
        wait_n(1000);
        check("run_1s_running", running, 1'b1);
        check("run_1s_hex_lag", hex, exp_hex(24'h000099));
        wait_n(1);
        check("run_1s_hex", hex, exp_hex(24'h000100));
        pulse_ss();
        check("stop_running", running, 1'b0);

        start_from(24'h005999);
        wait_n(10);
        check("min_carry_lag", hex, exp_hex(24'h005999));
        wait_n(1);
        check("min_carry", hex, exp_hex(24'h010000));
        pulse_ss();

        start_from(24'h995999);
        wait_n(9);
        check("wrap_ovf_pre", overflow, 1'b0);
        wait_n(1);
        check("wrap_ovf", overflow, 1'b1);
        wait_n(1);
        check("wrap_hex",     hex,     exp_hex(24'h000000));
        check("wrap_running", running, 1'b1);
        wait_n(20);
        check("wrap_count", hex, exp_hex(24'h000002));
        pulse_clr();
        check("clr_run_hex",     hex,      exp_hex(24'h000002));
        check("clr_run_ovf",     overflow, 1'b1);
        check("clr_run_running", running,  1'b1);
        pulse_ss();
        check("stop2_running", running, 1'b0);
        start_stop = 1'b1;
        clear      = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        check("ss_clr_running", running,  1'b1);
        check("ss_clr_ovf",     overflow, 1'b1);
        wait_n(1);
        check("ss_clr_hex", hex, exp_hex(24'h000002));
        pulse_ss();
        pulse_clr();
        check("clr_stop_ovf",     overflow, 1'b0);
        check("clr_stop_running", running,  1'b0);
        wait_n(1);
        check("clr_stop_hex", hex, exp_hex(24'h000000));

        start_from(24'h000000);
        wait_n(34);
        pulse_ss();
        wait_n(100);
        check("hold_stop_hex",     hex,     exp_hex(24'h000003));
        check("hold_stop_running", running, 1'b0);
        pulse_ss();
        wait_n(5);
        check("resume_lag_hex", hex, exp_hex(24'h000003));
        wait_n(1);
        check("resume_hex", hex, exp_hex(24'h000004));

`ifdef LAP_HOLD_EN
        pulse_ss();
        start_from(24'h000000);
        wait_n(200);
        pulse_lap();
        check("lap_arm", lap_hold, 1'b1);
        wait_n(100);
        check("lap_frozen_hex", hex, exp_hex(24'h000020));
        check("lap_still_held", lap_hold, 1'b1);
        pulse_lap();
        check("lap_release", lap_hold, 1'b0);
        wait_n(1);
        check("lap_live_hex", hex, exp_hex(24'h000030));
        pulse_ss();
        pulse_lap();
        check("lap_stopped_ignored", lap_hold, 1'b0);
        pulse_ss();
`else
        pulse_lap();
        check("lap_disabled", lap_hold, 1'b0);
`endif

        wait_n(15);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_running", running, 1'b0);
        check("async_rst_hex",     hex,     exp_hex(24'h000000));
        check("async_rst_ovf",     overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_n(3);
        check("post_rst_hex",     hex,     exp_hex(24'h000000));
        check("post_rst_running", running, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
